// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one variable-latency memory bus,
// with byte-lane steering for stores and zero/sign extension for byte loads.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t      state, state_n;
  logic        last_data;
  logic [7:0]  cnt;
  logic [1:0]  size_q;
  logic        lane_q;
  logic        grant_d, grant_f, done, abort;
  logic        d_byte;
  logic [7:0]  lane_b;
  logic [DATA_W-1:0] load_ext;

  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req && !d_valid;
  assign d_byte   = (d_size == 2'b01) || (d_size == 2'b10);

  always_comb begin
    lane_b = lane_q ? mem_rdata[15:8] : mem_rdata[7:0];
    case (size_q)
      2'b01:   load_ext = {{(DATA_W-8){1'b0}}, lane_b};
      2'b10:   load_ext = {{(DATA_W-8){lane_b[7]}}, lane_b};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Data wins a tie unless it also won the previous grant, so fetch never starves.
  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_f = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || !last_data)) begin
          grant_d = 1'b1;
          state_n = DATA;
        end else if (if_req) begin
          grant_f = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH, DATA: begin
        if (mem_ack) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (cnt == TO) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data <= 1'b0;
      cnt       <= '0;
      size_q    <= '0;
      lane_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      bus_err  <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= {d_addr[ADDR_W-1:1], 1'b0};
        mem_be    <= (d_we && d_byte) ? (d_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        mem_wdata <= d_byte ? {2{d_wdata[7:0]}} : d_wdata;
        size_q    <= d_size;
        lane_q    <= d_addr[0];
        cnt       <= '0;
        last_data <= 1'b1;
      end
      if (grant_f) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_be    <= 2'b11;
        mem_wdata <= '0;
        size_q    <= 2'b00;
        lane_q    <= 1'b0;
        cnt       <= '0;
        last_data <= 1'b0;
      end
      if (state != IDLE && !done && !abort)
        cnt <= cnt + 8'd1;
      if (done || abort) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        bus_err <= abort;
        if (state == FETCH) begin
          if_valid <= 1'b1;
          if_rdata <= abort ? '0 : mem_rdata;
        end else begin
          d_valid <= 1'b1;
          d_rdata <= (abort || mem_we) ? '0 : load_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, arbitration order, byte loads/stores,
// timeout abort and asynchronous reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid, if_stall;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        d_valid, d_stall;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_be;
  logic        mem_ack, bus_err;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_d_valid", 32'(d_valid), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_if_rdata", 32'(if_rdata), 0);
    chk("rst_d_rdata", 32'(d_rdata), 0);
    reset = 1'b0;
    tick();

    // fetch only, three wait cycles before ack
    if_req = 1; if_addr = 16'h0100;
    #1 chk("f_stall_pre", 32'(if_stall), 1);
    tick();
    chk("f_mem_req", 32'(mem_req), 1);
    chk("f_mem_be", 32'(mem_be), 2'b11);
    chk("f_mem_we", 32'(mem_we), 0);
    chk("f_mem_addr", 32'(mem_addr), 16'h0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("f_wait_valid", 32'(if_valid), 0);
      chk("f_wait_stall", 32'(if_stall), 1);
      chk("f_wait_req", 32'(mem_req), 1);
    end
    mem_ack = 1; mem_rdata = 16'hA5C3;
    tick();
    mem_ack = 0;
    chk("f_valid", 32'(if_valid), 1);
    chk("f_rdata", 32'(if_rdata), 16'hA5C3);
    chk("f_stall_done", 32'(if_stall), 0);
    chk("f_req_drop", 32'(mem_req), 0);
    if_req = 0;
    tick();
    chk("f_valid_once", 32'(if_valid), 0);
    chk("f_rdata_hold", 32'(if_rdata), 16'hA5C3);

    // both requests after reset: DATA, FETCH, DATA
    reset = 1; tick(); reset = 0; tick();
    if_req = 1; if_addr = 16'h0200;
    d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 16'h0040;
    tick();
    chk("arb1_addr_data", 32'(mem_addr), 16'h0040);
    chk("arb1_d_stall", 32'(d_stall), 1);
    mem_ack = 1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 0;
    chk("arb1_d_valid", 32'(d_valid), 1);
    chk("arb1_d_rdata", 32'(d_rdata), 16'h1234);
    tick();
    chk("arb2_addr_fetch", 32'(mem_addr), 16'h0200);
    chk("arb2_req", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 0;
    chk("arb2_if_valid", 32'(if_valid), 1);
    chk("arb2_if_rdata", 32'(if_rdata), 16'hCAFE);
    if_req = 0;
    tick();
    chk("arb3_addr_data", 32'(mem_addr), 16'h0040);
    mem_ack = 1; mem_rdata = 16'h5678;
    tick();
    mem_ack = 0;
    chk("arb3_d_valid", 32'(d_valid), 1);
    chk("arb3_d_rdata", 32'(d_rdata), 16'h5678);
    d_req = 0;
    tick();

    // byte loads from the high lane, sign then zero extension
    for (int k = 0; k < 2; k++) begin
      d_req = 1; d_we = 0; d_addr = 16'h0011;
      d_size = (k == 0) ? 2'b10 : 2'b01;
      tick();
      chk("lb_mem_addr", 32'(mem_addr), 16'h0010);
      chk("lb_mem_be", 32'(mem_be), 2'b11);
      mem_ack = 1; mem_rdata = 16'h80FF;
      tick();
      mem_ack = 0;
      chk("lb_valid", 32'(d_valid), 1);
      chk(k == 0 ? "lb_sext" : "lb_zext", 32'(d_rdata), k == 0 ? 32'hFF80 : 32'h0080);
      d_req = 0;
      tick();
    end

    // no ack: five request cycles, then abort; pending fetch follows
    d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 16'h0030;
    tick();
    if_req = 1; if_addr = 16'h0300;
    for (int i = 0; i < 5; i++) begin
      chk("to_req_high", 32'(mem_req), 1);
      chk("to_no_err", 32'(bus_err), 0);
      tick();
    end
    chk("to_req_drop", 32'(mem_req), 0);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_d_valid", 32'(d_valid), 1);
    chk("to_d_rdata", 32'(d_rdata), 0);
    chk("to_if_valid", 32'(if_valid), 0);
    d_req = 0;
    tick();
    chk("to_err_pulse", 32'(bus_err), 0);
    chk("to_next_fetch", 32'(mem_addr), 16'h0300);
    chk("to_next_req", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 0;
    chk("to_fetch_valid", 32'(if_valid), 1);
    chk("to_fetch_rdata", 32'(if_rdata), 16'hBEEF);
    if_req = 0;
    tick();

    // restore a nonzero load result, then byte store to the low lane
    d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 16'h0060;
    tick();
    mem_ack = 1; mem_rdata = 16'h4321;
    tick();
    mem_ack = 0;
    chk("pre_st_rdata", 32'(d_rdata), 16'h4321);
    d_req = 0;
    tick();
    d_req = 1; d_we = 1; d_size = 2'b01; d_addr = 16'h0020; d_wdata = 16'h773C;
    tick();
    chk("sb_mem_we", 32'(mem_we), 1);
    chk("sb_mem_be", 32'(mem_be), 2'b01);
    chk("sb_mem_wdata", 32'(mem_wdata), 16'h3C3C);
    chk("sb_mem_addr", 32'(mem_addr), 16'h0020);
    mem_ack = 1; mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 0;
    chk("sb_valid", 32'(d_valid), 1);
    chk("sb_rdata", 32'(d_rdata), 0);
    d_req = 0; d_we = 0;
    tick();

    // asynchronous reset in the middle of a data wait
    d_req = 1; d_size = 2'b00; d_addr = 16'h0050;
    tick();
    chk("rs_req_up", 32'(mem_req), 1);
    tick();
    #2 reset = 1;
    #1;
    chk("rs_req_async", 32'(mem_req), 0);
    chk("rs_d_valid", 32'(d_valid), 0);
    chk("rs_bus_err", 32'(bus_err), 0);
    d_req = 0;
    tick();
    reset = 0;
    mem_ack = 1; mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 0;
    chk("rs_late_ack_valid", 32'(d_valid), 0);
    chk("rs_late_ack_ifv", 32'(if_valid), 0);
    chk("rs_late_ack_req", 32'(mem_req), 0);
    tick();
    chk("rs_idle_valid", 32'(d_valid), 0);
    chk("rs_idle_rdata", 32'(d_rdata), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch stage and the data-memory stage (LW, LoadByte, SW, SV). It serializes the two requesters onto one variable-latency memory bus and performs byte-lane selection and extension for loads. It holds each requester stalled until its transaction completes and aborts transactions the memory never acknowledges. It sits between the IF/MEM pipeline stages and the memory model, and its stall outputs feed the pipeline's stall network.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data word width (fixed at 16; byte logic assumes two lanes)
- TIMEOUT, 15, maximum wait cycles for mem_ack before abort (1..255)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch word address
- if_rdata  out  DATA_W  fetched instruction, registered
- if_valid  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req && !if_valid (combinational)
- d_req  in  1  data request; fields held stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 word, 01 byte zero-extend, 10 byte sign-extend; 11 treated as 00
- d_addr  in  ADDR_W  byte address; bit 0 selects lane for byte ops
- d_wdata  in  DATA_W  store data; byte stores use d_wdata[7:0]
- d_rdata  out  DATA_W  load result, registered, extended per d_size
- d_valid  out  1  one-cycle completion pulse for data
- d_stall  out  1  d_req && !d_valid (combinational)
- mem_req  out  1  bus request, held until ack or abort
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address (d_addr with bit 0 cleared for data)
- mem_wdata  out  DATA_W  bus write data; byte stores replicate the byte to both lanes
- mem_be  out  2  lane enables; 11 for words and reads, 01/10 for byte stores per addr[0]
- mem_rdata  in  DATA_W  bus read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory
- bus_err  out  1  one-cycle pulse when a transaction times out

## Operation
- States are IDLE, FETCH and DATA. A last_data flag records whether the most recent grant was data.
- In IDLE, when the only request is d_req, go to DATA. When the only request is if_req, go to FETCH.
- In IDLE, when both are requested, go to DATA unless last_data=1, in which case go to FETCH. This prevents fetch starvation under back-to-back loads.
- On grant, latch the requester's address, write data, size and we into the bus registers. Clear the wait counter and set or clear last_data.
- In FETCH/DATA, mem_req=1. When mem_ack=1, capture read data, pulse the matching *_valid next cycle and return to IDLE.
- Load extension:
  - Word: d_rdata = mem_rdata.
  - Byte: lane = addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]. Zero-extend or sign-extend per d_size.
- Stores: d_valid pulses on completion, and d_rdata is 0.
- Timeout: the wait counter increments each FETCH/DATA cycle without ack. On reaching TIMEOUT:
  - drop mem_req;
  - pulse bus_err and the matching *_valid, with rdata = 0;
  - go to IDLE.
- A request that is high in the same cycle its *_valid pulses is a new request and is eligible for arbitration that cycle. A requester must deassert req to avoid reissue.
- A mem_ack while IDLE is ignored.

## Timing
- Reset (asynchronous) forces:
  - state IDLE, last_data=0, counter 0;
  - all outputs 0, including mem_req, which drops immediately;
  - an in-flight transaction is discarded with no valid pulse.
- Grant edge: mem_req is high from the edge after the request is sampled in IDLE.
- Minimum latency is 2 cycles: req seen at edge0, mem_ack during cycle 1, *_valid and rdata during cycle 2.
- Completion to next grant has no bubble: the valid cycle is an IDLE cycle, so the next mem_req rises at the following edge.
- A timeout pulse occurs TIMEOUT+1 cycles after grant when no ack arrives.
- mem_* outputs are registered and stable for the whole transaction.
- *_rdata holds its value until the next completion of the same requester.

## Test plan
- Fetch only, ack after 3 wait cycles, mem_rdata=16'hA5C3 -> if_valid pulses once with if_rdata=A5C3. if_stall is high until that cycle. mem_be=11, mem_we=0.
- Both requests simultaneously after reset, and d_req re-raised immediately after completion -> grant order is DATA, FETCH, DATA. Fetch is never skipped twice.
- LoadByte sign-extend at address 0x0011 with mem_rdata=16'h80FF -> mem_addr=0x0010 and d_rdata=16'hFF80. Repeat with d_size=01 -> d_rdata=16'h0080.
- Byte store 8'h3C to address 0x0020 -> mem_we=1, mem_be=01, mem_wdata=16'h3C3C. Then d_valid pulses with d_rdata=0.
- No ack with TIMEOUT=4 -> mem_req is high for 5 cycles, then bus_err and d_valid pulse together with d_rdata=0. A pending fetch is granted next.
- Assert reset during DATA wait -> mem_req, d_valid and bus_err are 0 immediately. After release, a late mem_ack is ignored and no valid pulse occurs.
